complex_acc: RTL and testbench

COMPLEX_ACC -- requirements
Module: complex_acc

---
 rtl/complex_pkg.sv | 21 ++
 rtl/complex_acc_sat_add.sv | 33 +++
 rtl/complex_acc.sv | 97 +++++++++
 tb/tb_complex_acc.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_pkg.sv
// Shared types and constants for the complex frame accumulator.
// Component width, beat-count width, clamp limits and FSM state.
package complex_pkg;

    localparam int W  = 64;
    localparam int CW = 16;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
    } cplx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/complex_acc_sat_add.sv
// Signed W-bit adder that clamps to the representable range.
// ovf flags either clamp direction.
module sat_add #(
    parameter int W = complex_pkg::W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] wide;

    assign wide = {a[W-1], a} + {b[W-1], b};

    // Top two bits of the W+1 sum disagree only on overflow.
    always_comb begin
        sum = wide[W-1:0];
        ovf = 1'b0;
        unique case (1'b1)
            !wide[W] && wide[W-1]: begin
                sum = {1'b0, {(W-1){1'b1}}};
                ovf = 1'b1;
            end
            wide[W] && !wide[W-1]: begin
                sum = {1'b1, {(W-1){1'b0}}};
                ovf = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/complex_acc.sv
// Saturating per-frame accumulator of complex products.
// Emits sum, beat count and sticky overflow one cycle after in_last.
module complex_acc
    import complex_pkg::state_t, complex_pkg::IDLE, complex_pkg::ACCUM;
#(
    parameter int W  = complex_pkg::W,
    parameter int CW = complex_pkg::CW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*W-1:0]  in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [2*W-1:0]  out_data,
    output logic [CW-1:0]   out_count,
    output logic            out_ovf,
    output logic            out_valid,
    input  logic            out_ready
);

    state_t        state, state_d;
    logic [W-1:0]  acc_re, acc_im;
    logic [W-1:0]  sum_re, sum_im;
    logic [CW-1:0] count, count_inc;
    logic          ovf, ovf_re, ovf_im, frame_ovf;
    logic          accept, take;

    assign in_ready  = !(out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign frame_ovf = ovf | ovf_re | ovf_im;

    assign count_inc = (count == {CW{1'b1}}) ? count
                                             : count + CW'(1);

    sat_add #(.W(W)) u_re (
        .a   (acc_re),
        .b   (in_data[2*W-1:W]),
        .sum (sum_re),
        .ovf (ovf_re)
    );

    sat_add #(.W(W)) u_im (
        .a   (acc_im),
        .b   (in_data[W-1:0]),
        .sum (sum_im),
        .ovf (ovf_im)
    );

    always_comb begin
        state_d = state;
        unique case (1'b1)
            accept && in_last:  state_d = IDLE;
            accept && !in_last: state_d = ACCUM;
            default:            state_d = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc_re    <= '0;
            acc_im    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_d;
            if (accept && in_last) begin
                // Close the frame and reopen empty in the same cycle.
                acc_re    <= '0;
                acc_im    <= '0;
                count     <= '0;
                ovf       <= 1'b0;
                out_data  <= {sum_re, sum_im};
                out_count <= count_inc;
                out_ovf   <= frame_ovf;
                out_valid <= 1'b1;
            end else begin
                if (accept) begin
                    acc_re <= sum_re;
                    acc_im <= sum_im;
                    count  <= count_inc;
                    ovf    <= frame_ovf;
                end
                if (take) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_acc.sv
// Scoreboard bench for complex_acc: directed frames plus a
// randomised run against a saturating reference model.
module tb_complex_acc;
    import complex_pkg::*;

    typedef struct {
        logic [2*W-1:0] data;
        logic [CW-1:0]  cnt;
        logic           ovf;
        longint         due;
    } exp_t;

    logic           clk, rst;
    logic [2*W-1:0] in_data;
    logic           in_valid, in_last, in_ready;
    logic [2*W-1:0] out_data;
    logic [CW-1:0]  out_count;
    logic           out_ovf, out_valid, out_ready;

    exp_t   q[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    int     rdy_mode = 0;
    int     stall_cnt = 0;
    bit     mon_en = 0;
    bit     seen = 0;
    int     waits;

    logic [W-1:0]  m_re, m_im;
    logic [CW-1:0] m_cnt;
    logic          m_ovf;

    complex_acc #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic ok,
                         input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] msat(input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        logic signed [W:0] s, mx, mn;
        mx = {2'b00, {(W-1){1'b1}}};
        mn = {2'b11, {(W-1){1'b0}}};
        s  = $signed({a[W-1], a}) + $signed({b[W-1], b});
        if (s > mx) return {1'b1, SAT_MAX};
        if (s < mn) return {1'b1, SAT_MIN};
        return {1'b0, s[W-1:0]};
    endfunction

    task automatic model_clear();
        m_re = '0; m_im = '0; m_cnt = '0; m_ovf = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic last, input logic hand,
                        input logic [2*W-1:0] hd, input logic [CW-1:0] hc,
                        input logic ho);
        logic [W:0]    r, i;
        logic [CW-1:0] c;
        exp_t          e;
        bit            done;
        done  = 0;
        waits = 0;
        @(negedge clk);
        in_data  = {re, im};
        in_last  = last;
        in_valid = 1'b1;
        while (!done) begin
            #1;
            if (in_ready) begin
                done = 1;
                r = msat(m_re, re);
                i = msat(m_im, im);
                c = (m_cnt == {CW{1'b1}}) ? m_cnt : m_cnt + CW'(1);
                if (last) begin
                    e.data = hand ? hd : {r[W-1:0], i[W-1:0]};
                    e.cnt  = hand ? hc : c;
                    e.ovf  = hand ? ho : (m_ovf | r[W] | i[W]);
                    e.due  = cyc + 1;
                    q.push_back(e);
                    model_clear();
                end else begin
                    m_re  = r[W-1:0];
                    m_im  = i[W-1:0];
                    m_cnt = c;
                    m_ovf = m_ovf | r[W] | i[W];
                end
            end else begin
                waits++;
                if (waits > 200) begin
                    check("in_ready_timeout", 1'b0, 0, 1);
                    done = 1;
                end
            end
            @(posedge clk);
            if (!done) @(negedge clk);
        end
    endtask

    task automatic beat(input logic [W-1:0] re, input logic [W-1:0] im);
        send(re, im, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic last_hand(input logic [W-1:0] re,
                             input logic [W-1:0] im,
                             input logic [2*W-1:0] d,
                             input logic [CW-1:0] c, input logic o);
        send(re, im, 1'b1, 1'b1, d, c, o);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_out_data", out_data == '0, out_data, 0);
        check("rst_out_count", out_count == '0, out_count, 0);
        check("rst_out_ovf", out_ovf == 1'b0, out_ovf, 0);
        rst = 1'b0;
        q.delete();
        seen = 0;
        model_clear();
        @(negedge clk);
        #1;
        check("in_ready_after_rst", in_ready == 1'b1, in_ready, 1);
    endtask

    task automatic wait_empty();
        int g;
        g = 0;
        idle(1);
        while (q.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("drain", q.size() == 0, q.size(), 0);
    endtask

    function automatic logic [W-1:0] rnd_comp();
        longint v;
        unique case ($urandom_range(0, 3))
            0: return {$urandom, $urandom};
            1: return SAT_MAX - W'($urandom_range(0, 50));
            2: return SAT_MIN + W'($urandom_range(0, 50));
            default: begin
                v = longint'($urandom_range(0, 2000)) - 1000;
                return v;
            end
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst) begin
                if (!out_valid) begin
                    check("in_ready_idle", in_ready == 1'b1, in_ready, 1);
                end else if (q.size() == 0) begin
                    check("unexpected_out", 1'b0, out_data, 0);
                end else begin
                    e = q[0];
                    if (!seen) begin
                        check("latency", cyc == e.due, cyc, e.due);
                        seen = 1;
                    end
                    check("out_data", out_data == e.data, out_data, e.data);
                    if (out_ready) begin
                        check("in_ready_take", in_ready == 1'b1, in_ready, 1);
                        check("out_count", out_count == e.cnt,
                              out_count, e.cnt);
                        check("out_ovf", out_ovf == e.ovf, out_ovf, e.ovf);
                        void'(q.pop_front());
                        seen = 0;
                    end else begin
                        stall_cnt++;
                        check("in_ready_stall", in_ready == 1'b0, in_ready, 0);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] k;
        clk = 1'b0; rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        out_ready = 1'b1;
        model_clear();
        do_reset();
        mon_en = 1;

        beat(64'd1, 64'd2);
        beat(64'd3, -64'sd4);
        last_hand(64'd5, 64'd6, {64'd9, 64'd4}, 16'd3, 1'b0);

        beat(SAT_MAX, 64'd0);
        last_hand(64'd1, 64'd0, {SAT_MAX, 64'd0}, 16'd2, 1'b1);
        last_hand(64'd1, 64'd1, {64'd1, 64'd1}, 16'd1, 1'b0);

        beat(SAT_MIN, 64'd0);
        last_hand(-64'sd1, 64'd0, {SAT_MIN, 64'd0}, 16'd2, 1'b1);
        beat(64'd0, SAT_MAX);
        last_hand(64'd0, SAT_MAX, {64'd0, SAT_MAX}, 16'd2, 1'b1);
        beat(SAT_MAX, 64'd0);
        beat(64'd1, 64'd0);
        last_hand(-64'sd1, 64'd0,
                  {64'h7FFF_FFFF_FFFF_FFFE, 64'd0}, 16'd2 + 16'd1, 1'b1);
        wait_empty();

        for (int n = 1; n <= 8; n++) begin
            k = W'(n);
            last_hand(k, -k, {k, -k}, 16'd1, 1'b0);
            check("b2b_no_wait", waits == 0, waits, 0);
        end
        wait_empty();

        rdy_mode  = 2;
        stall_cnt = 0;
        last_hand(64'd3, 64'd4, {64'd3, 64'd4}, 16'd1, 1'b0);
        fork
            begin
                repeat (8) @(posedge clk);
                rdy_mode = 0;
            end
        join_none
        last_hand(64'd5, 64'd5, {64'd5, 64'd5}, 16'd1, 1'b0);
        wait_empty();
        check("stall_cycles", stall_cnt >= 5, stall_cnt, 5);

        beat(64'd1, 64'd1);
        beat(64'd2, 64'd2);
        do_reset();
        last_hand(64'd7, 64'd7, {64'd7, 64'd7}, 16'd1, 1'b0);
        wait_empty();

        rdy_mode = 1;
        for (int f = 0; f < 1000; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int b = 1; b <= len; b++) begin
                send(rnd_comp(), rnd_comp(), b == len,
                     1'b0, '0, '0, 1'b0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        wait_empty();
        rdy_mode = 0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
